// File: rtl/astream_rr_arbiter_if.sv
// Stream bundle between NUM_IN requesters, the arbiter and one consumer.
// Ports: din/val_in/ready_upward (requesters), dout/val_out/ready_downward, grant/grant_valid.
interface astream_rr_arbiter_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_IN       = 4,
  parameter int GW           = $clog2(NUM_IN)
);
  logic [NUM_IN*PAYLOAD_BITS-1:0] din;
  logic [NUM_IN-1:0]              val_in;
  logic [NUM_IN-1:0]              ready_upward;
  logic [PAYLOAD_BITS-1:0]        dout;
  logic                           val_out;
  logic                           ready_downward;
  logic [GW-1:0]                  grant;
  logic                           grant_valid;

  modport slave (
    input  din, val_in, ready_downward,
    output ready_upward, dout, val_out,
    output grant, grant_valid
  );

  modport master (
    output din, val_in, ready_downward,
    input  ready_upward, dout, val_out,
    input  grant, grant_valid
  );
endinterface

// File: rtl/astream_rr_arbiter.sv
// Round-robin burst arbiter: NUM_IN streams share one registered output.
// Ports: clk, reset_n (sync, active-low), bus (slave view of the stream bundle).
module astream_rr_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_IN       = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic clk,
  input  logic reset_n,
  astream_rr_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_IN);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [CW-1:0]           beat_q, beat_d;
  logic                    val_out_q, val_out_d;
  logic [PAYLOAD_BITS-1:0] dout_q, dout_d;

  logic                    out_free;
  logic                    own_val;
  logic                    xfer;
  logic                    any_req;
  logic                    last_beat;
  logic [GW-1:0]           pick;
  logic [GW-1:0]           cand;
  logic [PAYLOAD_BITS-1:0] own_din;

  assign out_free  = ~val_out_q | bus.ready_downward;
  assign own_val   = bus.val_in[grant_q];
  assign own_din   = bus.din[int'(grant_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign xfer      = (state_q == BUSY) & own_val & out_free;
  assign any_req   = |bus.val_in;
  assign last_beat = (beat_q == CW'(MAX_BURST - 1));

  // Scan from the farthest offset down so the nearest
  // requester after last_grant wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NUM_IN);
      if (bus.val_in[cand]) pick = cand;
    end
  end

  always_comb begin
    bus.ready_upward = '0;
    if (state_q == BUSY) bus.ready_upward[grant_q] = out_free;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    val_out_d = val_out_q;
    dout_d    = dout_q;

    if (xfer) begin
      dout_d    = own_din;
      val_out_d = 1'b1;
    end else if (bus.ready_downward) begin
      val_out_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer && last_beat) begin
          state_d = IDLE;
          last_d  = grant_q;
          beat_d  = '0;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end else if (!own_val) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NUM_IN - 1);
      beat_q    <= '0;
      val_out_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      val_out_q <= val_out_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.val_out     = val_out_q;
  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == BUSY);
endmodule
